// File: rtl/tcdm_interconnect_xbar_if.sv
// TCDM port bundle shared by both sides of tcdm_interconnect_xbar.
// One instance carries N ports of request/grant/response signals.
// The master modport is the initiator side and the slave modport is the target side.
// On the bank side the vld wire exists but carries no meaning: bank read data
// is valid exactly one cycle after an accepted request.
interface tcdm_interconnect_xbar_if #(
   parameter int N  = 4,
   parameter int AW = 32,
   parameter int DW = 32
);
   localparam int BW = DW / 8;

   logic [N-1:0]         req;
   logic [N-1:0][AW-1:0] add;
   logic [N-1:0]         wen;
   logic [N-1:0][DW-1:0] wdata;
   logic [N-1:0][BW-1:0] be;
   logic [N-1:0]         gnt;
   logic [N-1:0]         vld;
   logic [N-1:0][DW-1:0] rdata;

   modport master (
      output req, add, wen, wdata, be,
      input  gnt, vld, rdata
   );

   modport slave (
      input  req, add, wen, wdata, be,
      output gnt, vld, rdata
   );
endinterface

// File: rtl/tcdm_interconnect_xbar.sv
// Single-stage TCDM crossbar between NumIn masters and NumOut single-ported banks.
//
// Routing:
//   - Requests are routed by word-interleaved address bits.
//   - Each bank arbitrates combinationally among its candidates.
//   - Responses return to the originator one cycle after the grant.
//
// Arbitration is selected by the macro TCDM_XBAR_RR_EN:
//   - Defined: round-robin with one pointer per bank.
//   - Undefined: fixed priority (lowest input index wins), with no pointer state.
module tcdm_interconnect_xbar #(
   parameter int NumIn        = 4,
   parameter int NumOut       = 4,
   parameter int AddrWidth    = 32,
   parameter int DataWidth    = 32,
   parameter int AddrMemWidth = 10,
   parameter bit WriteRespOn  = 1'b1
) (
   input logic                      clk_i,
   input logic                      rst_i,
   tcdm_interconnect_xbar_if.slave  mst,
   tcdm_interconnect_xbar_if.master bank
);

   localparam int BeWidth  = DataWidth / 8;
   localparam int OffW     = $clog2(BeWidth);
   localparam int SelW     = (NumOut > 1) ? $clog2(NumOut) : 0;
   localparam int BankIdxW = (NumOut > 1) ? SelW : 1;
   localparam int InIdxW   = (NumIn > 1) ? $clog2(NumIn) : 1;

   typedef logic [InIdxW-1:0]   in_idx_t;
   typedef logic [BankIdxW-1:0] bank_idx_t;

   // Address decode results per master.
   bank_idx_t [NumIn-1:0]                   tgt;
   logic      [NumIn-1:0][AddrMemWidth-1:0] mem_add;

   // Per-bank arbitration results.
   logic    [NumOut-1:0] bank_req;
   in_idx_t [NumOut-1:0] win;
   logic    [NumOut-1:0] accept;

   // Bank-side request payload.
   logic [NumOut-1:0][AddrMemWidth-1:0] bank_add;
   logic [NumOut-1:0]                   bank_wen;
   logic [NumOut-1:0][DataWidth-1:0]    bank_wdata;
   logic [NumOut-1:0][BeWidth-1:0]      bank_be;

   // Master-side responses.
   logic [NumIn-1:0]                mst_gnt;
   logic [NumIn-1:0]                mst_vld;
   logic [NumIn-1:0][DataWidth-1:0] mst_rdata;

   // Response return registers: one outstanding response per bank.
   logic    [NumOut-1:0] rsp_vld;
   in_idx_t [NumOut-1:0] rsp_idx;

`ifdef TCDM_XBAR_RR_EN
   // Round-robin pointer per bank: the first input index considered.
   in_idx_t [NumOut-1:0] ptr;
`endif

   // Address bits outside the offset/select/word fields are don't-care,
   // as is the bank-side vld wire.
   logic unused_bits;
   assign unused_bits = ^{mst.add, bank.vld};

   // Split each master address into target bank and bank word address.
   for (genvar i = 0; i < NumIn; i++) begin : g_dec
      if (NumOut > 1) begin : g_sel
         assign tgt[i] = mst.add[i][OffW +: BankIdxW];
      end else begin : g_one
         assign tgt[i] = '0;
      end
      assign mem_add[i] = mst.add[i][OffW+SelW +: AddrMemWidth];
   end

   // Per-bank winner search among requesters targeting that bank.
   always_comb begin
      int idx;
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      bank_req = '0;
      win      = '0;
      idx      = 0;
      for (int b = 0; b < NumOut; b++) begin
         for (int k = 0; k < NumIn; k++) begin
`ifdef TCDM_XBAR_RR_EN
            idx = int'(ptr[b]) + k;
            if (idx >= NumIn) begin
               idx = idx - NumIn;
            end
`else
            idx = k;
`endif
            if (!bank_req[b] && mst.req[idx] && (tgt[idx] == bank_idx_t'(b))) begin
               bank_req[b] = 1'b1;
               win[b]      = in_idx_t'(idx);
            end
         end
      end
   end

   // Forward the winner's payload to its bank; idle banks see zeros.
   always_comb begin
      bank_add   = '0;
      bank_wen   = '0;
      bank_wdata = '0;
      bank_be    = '0;
      for (int b = 0; b < NumOut; b++) begin
         if (bank_req[b]) begin
            bank_add[b]   = mem_add[win[b]];
            bank_wen[b]   = mst.wen[win[b]];
            bank_wdata[b] = mst.wdata[win[b]];
            bank_be[b]    = mst.be[win[b]];
         end
      end
   end

   assign bank.req   = bank_req;
   assign bank.add   = bank_add;
   assign bank.wen   = bank_wen;
   assign bank.wdata = bank_wdata;
   assign bank.be    = bank_be;

   // A bank accepts when it has a winner and the bank itself is ready.
   assign accept = bank_req & bank.gnt;

   // Grant each bank's winner in the same cycle the bank accepts it.
   always_comb begin
      mst_gnt = '0;
      for (int b = 0; b < NumOut; b++) begin
         if (accept[b]) begin
            mst_gnt[win[b]] = 1'b1;
         end
      end
   end

   // Response valid per bank: set by accepted reads (and by writes when enabled).
   // Reset clears it, so a request accepted under reset never answers.
   always_ff @(posedge clk_i) begin
      // NOTE: state is updated with non-blocking assignments only, so all flops see pre-edge values.
      if (rst_i) begin
         rsp_vld <= '0;
      end else begin
         for (int b = 0; b < NumOut; b++) begin
            rsp_vld[b] <= accept[b] & (WriteRespOn | ~bank_wen[b]);
         end
      end
   end

   // Remember which master each bank is answering next cycle.
   always_ff @(posedge clk_i) begin
      // NOTE: rsp_idx is datapath qualified by rsp_vld, so it deliberately has no reset.
      for (int b = 0; b < NumOut; b++) begin
         if (accept[b]) begin
            rsp_idx[b] <= win[b];
         end
      end
   end

`ifdef TCDM_XBAR_RR_EN
   // Move each bank's priority just past the input it has served.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr <= '0;
      end else begin
         for (int b = 0; b < NumOut; b++) begin
            if (accept[b]) begin
               ptr[b] <= (win[b] == in_idx_t'(NumIn - 1)) ? '0 : win[b] + 1'b1;
            end
         end
      end
   end
`endif

   // Route registered responses and bank read data back to their originators.
   always_comb begin
      mst_vld   = '0;
      mst_rdata = '0;
      for (int b = 0; b < NumOut; b++) begin
         if (rsp_vld[b]) begin
            mst_vld[rsp_idx[b]]   = 1'b1;
            mst_rdata[rsp_idx[b]] = bank.rdata[b];
         end
      end
   end

   assign mst.gnt   = mst_gnt;
   assign mst.vld   = mst_vld;
   assign mst.rdata = mst_rdata;

endmodule

// File: tb/tb_tcdm_interconnect_xbar.sv
// Self-checking bench for tcdm_interconnect_xbar (4 masters, 4 banks).
// Directed stimulus drives the masters. A bank model serves reads and writes.
// Expected responses are queued at issue time; a monitor pops and compares them
// whenever vld_o rises.
module tb_tcdm_interconnect_xbar;

   localparam int NumIn        = 4;
   localparam int NumOut       = 4;
   localparam int AddrWidth    = 32;
   localparam int DataWidth    = 32;
   localparam int AddrMemWidth = 10;
   localparam bit WriteRespOn  = 1'b1;
`ifdef TCDM_XBAR_RR_EN
   localparam bit RrEn = 1'b1;
`else
   localparam bit RrEn = 1'b0;
`endif

   logic clk_i = 1'b0;
   logic rst_i;
   always #5 clk_i = ~clk_i;

   tcdm_interconnect_xbar_if #(.N(NumIn),  .AW(AddrWidth),    .DW(DataWidth)) mst_bus ();
   tcdm_interconnect_xbar_if #(.N(NumOut), .AW(AddrMemWidth), .DW(DataWidth)) bank_bus ();

   tcdm_interconnect_xbar #(
      .NumIn        (NumIn),
      .NumOut       (NumOut),
      .AddrWidth    (AddrWidth),
      .DataWidth    (DataWidth),
      .AddrMemWidth (AddrMemWidth),
      .WriteRespOn  (WriteRespOn)
   ) dut (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .mst   (mst_bus),
      .bank  (bank_bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   typedef struct {
      int          idx;
      logic [31:0] data;
      bit          chk;
   } exp_t;
   exp_t sb_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // ---------------- bank model ----------------
   logic [NumOut-1:0] gnt_en;
   logic [31:0]       mem [NumOut][1024];

   assign bank_bus.gnt = bank_bus.req & gnt_en;
   assign bank_bus.vld = '0;

   initial begin
      for (int b = 0; b < NumOut; b++) begin
         for (int a = 0; a < 1024; a++) begin
            mem[b][a] = 32'hA000_0000 | (b << 16) | a;
         end
      end
      mem[1][2] = 32'hDEAD_BEEF;
   end

   always @(posedge clk_i) begin
      for (int b = 0; b < NumOut; b++) begin
         if (bank_bus.req[b] && bank_bus.gnt[b]) begin
            if (bank_bus.wen[b]) begin
               for (int y = 0; y < 4; y++) begin
                  if (bank_bus.be[b][y]) begin
                     mem[b][bank_bus.add[b]][8*y +: 8] <= bank_bus.wdata[b][8*y +: 8];
                  end
               end
               bank_bus.rdata[b] <= '0;
            end else begin
               bank_bus.rdata[b] <= mem[b][bank_bus.add[b]];
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   always @(negedge clk_i) begin
      int k;
      if (mon_en) begin
         for (int i = 0; i < NumIn; i++) begin
            if (mst_bus.vld[i] === 1'b1) begin
               k = -1;
               for (int j = 0; j < sb_q.size(); j++) begin
                  if (k < 0 && sb_q[j].idx == i) k = j;
               end
               if (k < 0) begin
                  check($sformatf("unexpected_vld[%0d]", i), 32'(mst_bus.vld[i]), 32'h0);
               end else begin
                  if (sb_q[k].chk) begin
                     check($sformatf("rdata[%0d]", i), mst_bus.rdata[i], sb_q[k].data);
                  end
                  sb_q.delete(k);
               end
            end else begin
               check($sformatf("idle_rdata[%0d]", i), mst_bus.rdata[i], 32'h0);
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic clear_reqs();
      mst_bus.req   = '0;
      mst_bus.add   = '0;
      mst_bus.wen   = '0;
      mst_bus.wdata = '0;
      mst_bus.be    = '0;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic w,
                          input logic [31:0] d, input logic [3:0] bev);
      mst_bus.req[i]   = 1'b1;
      mst_bus.add[i]   = a;
      mst_bus.wen[i]   = w;
      mst_bus.wdata[i] = d;
      mst_bus.be[i]    = bev;
   endtask

   task automatic expect_rsp(input int i, input logic [31:0] d, input bit chk);
      exp_t e;
      e.idx  = i;
      e.data = d;
      e.chk  = chk;
      sb_q.push_back(e);
   endtask

   task automatic advance();
      @(posedge clk_i);
      #1;
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_i  = 1'b1;
      gnt_en = '1;
      clear_reqs();
      repeat (3) advance();
      @(negedge clk_i);
      check("reset_vld",   32'(mst_bus.vld), 32'h0);
      check("reset_rdata", mst_bus.rdata[0], 32'h0);
      check("reset_req_o", 32'(bank_bus.req), 32'h0);
      advance();
      rst_i  = 1'b0;
      mon_en = 1'b1;

      // Single read: input 0 -> bank 1, word 2.
      set_req(0, 32'h0000_0024, 1'b0, 32'h0, 4'hF);
      expect_rsp(0, 32'hDEAD_BEEF, 1'b1);
      @(negedge clk_i);
      check("t1_req_o",  32'(bank_bus.req), 32'h2);
      check("t1_add_o1", 32'(bank_bus.add[1]), 32'h2);
      check("t1_gnt_o",  32'(mst_bus.gnt), 32'h1);
      advance();
      clear_reqs();

      // Inputs 0,1,2 contend for bank 2; held until granted.
      set_req(0, 32'h08, 1'b0, 32'h0, 4'hF);
      set_req(1, 32'h18, 1'b0, 32'h0, 4'hF);
      set_req(2, 32'h28, 1'b0, 32'h0, 4'hF);
      expect_rsp(0, 32'hA002_0000, 1'b1);
      expect_rsp(1, 32'hA002_0001, 1'b1);
      expect_rsp(2, 32'hA002_0002, 1'b1);
      @(negedge clk_i);
      check("t2_req_o",  32'(bank_bus.req), 32'h4);
      check("t2_gnt_c0", 32'(mst_bus.gnt), 32'h1);
      advance();
      mst_bus.req[0] = 1'b0;
      @(negedge clk_i);
      check("t2_gnt_c1", 32'(mst_bus.gnt), 32'h2);
      advance();
      mst_bus.req[1] = 1'b0;
      @(negedge clk_i);
      check("t2_gnt_c2", 32'(mst_bus.gnt), 32'h4);
      advance();
      clear_reqs();

      // Inputs 0 and 3 on bank 2: round-robin pointer now favours 3.
      set_req(0, 32'h38, 1'b0, 32'h0, 4'hF);
      set_req(3, 32'h48, 1'b0, 32'h0, 4'hF);
      expect_rsp(0, 32'hA002_0003, 1'b1);
      expect_rsp(3, 32'hA002_0004, 1'b1);
      @(negedge clk_i);
      check("t2b_gnt_c0", 32'(mst_bus.gnt), RrEn ? 32'h8 : 32'h1);
      advance();
      if (RrEn) mst_bus.req[3] = 1'b0;
      else      mst_bus.req[0] = 1'b0;
      @(negedge clk_i);
      check("t2b_gnt_c1", 32'(mst_bus.gnt), RrEn ? 32'h1 : 32'h8);
      advance();
      clear_reqs();

      // Reset in the grant cycle: no response, pointers restart at 0.
      set_req(0, 32'h24, 1'b0, 32'h0, 4'hF);
      rst_i = 1'b1;
      @(negedge clk_i);
      check("t6_gnt_in_reset", 32'(mst_bus.gnt), 32'h1);
      advance();
      rst_i = 1'b0;
      clear_reqs();
      @(negedge clk_i);
      check("t6_vld_after_reset",   32'(mst_bus.vld), 32'h0);
      check("t6_rdata_after_reset", mst_bus.rdata[0], 32'h0);
      advance();
      set_req(0, 32'h68, 1'b0, 32'h0, 4'hF);
      set_req(2, 32'h78, 1'b0, 32'h0, 4'hF);
      expect_rsp(0, 32'hA002_0006, 1'b1);
      expect_rsp(2, 32'hA002_0007, 1'b1);
      @(negedge clk_i);
      check("t6_rr_restart_c0", 32'(mst_bus.gnt), 32'h1);
      advance();
      mst_bus.req[0] = 1'b0;
      @(negedge clk_i);
      check("t6_rr_restart_c1", 32'(mst_bus.gnt), 32'h4);
      advance();
      clear_reqs();

      // Four inputs to four distinct banks; input 3 uses ignored high/low bits.
      set_req(0, 32'h0000_0054, 1'b0, 32'h0, 4'hF);
      set_req(1, 32'h0000_0058, 1'b0, 32'h0, 4'hF);
      set_req(2, 32'h0000_005C, 1'b0, 32'h0, 4'hF);
      set_req(3, 32'hFFFF_C051, 1'b0, 32'h0, 4'hF);
      expect_rsp(0, 32'hA001_0005, 1'b1);
      expect_rsp(1, 32'hA002_0005, 1'b1);
      expect_rsp(2, 32'hA003_0005, 1'b1);
      expect_rsp(3, 32'hA000_0005, 1'b1);
      @(negedge clk_i);
      check("t3_req_o",  32'(bank_bus.req), 32'hF);
      check("t3_gnt_o",  32'(mst_bus.gnt), 32'hF);
      check("t3_add_o0", 32'(bank_bus.add[0]), 32'h5);
      advance();
      clear_reqs();

      // Write to bank 3 word 7 with be=0x3, then read it back.
      set_req(1, 32'h7C, 1'b1, 32'h1234_5678, 4'h3);
      if (WriteRespOn) expect_rsp(1, 32'h0, 1'b0);
      @(negedge clk_i);
      check("t4_req_o",    32'(bank_bus.req), 32'h8);
      check("t4_wen_o3",   32'(bank_bus.wen[3]), 32'h1);
      check("t4_be_o3",    32'(bank_bus.be[3]), 32'h3);
      check("t4_wdata_o3", bank_bus.wdata[3], 32'h1234_5678);
      check("t4_add_o3",   32'(bank_bus.add[3]), 32'h7);
      check("t4_gnt_o",    32'(mst_bus.gnt), 32'h2);
      advance();
      clear_reqs();
      set_req(0, 32'h7C, 1'b0, 32'h0, 4'hF);
      expect_rsp(0, 32'hA003_5678, 1'b1);
      @(negedge clk_i);
      check("t4_rd_gnt", 32'(mst_bus.gnt), 32'h1);
      check("t4_rd_wen", 32'(bank_bus.wen[3]), 32'h0);
      advance();
      clear_reqs();
      @(negedge clk_i);
      check("idle_req_o",   32'(bank_bus.req), 32'h0);
      check("idle_wdata_o", bank_bus.wdata[3], 32'h0);
      check("idle_be_o",    32'(bank_bus.be), 32'h0);

      // Bank 0 not ready: input 2 waits without grant or response.
      advance();
      gnt_en[0] = 1'b0;
      set_req(2, 32'h30, 1'b0, 32'h0, 4'hF);
      @(negedge clk_i);
      check("t5_req_o",     32'(bank_bus.req), 32'h1);
      check("t5_gnt_wait0", 32'(mst_bus.gnt), 32'h0);
      advance();
      @(negedge clk_i);
      check("t5_gnt_wait1", 32'(mst_bus.gnt), 32'h0);
      advance();
      gnt_en[0] = 1'b1;
      expect_rsp(2, 32'hA000_0003, 1'b1);
      @(negedge clk_i);
      check("t5_gnt_release", 32'(mst_bus.gnt), 32'h4);
      advance();
      clear_reqs();

      repeat (3) advance();
      check("sb_empty", 32'(sb_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tcdm_interconnect_xbar.md
Name: tcdm_interconnect_xbar

Overview:
Single-stage, fully combinational-request crossbar between NumIn TCDM masters (core/tile ports) and NumOut single-ported SRAM banks.
- Each request is routed to a bank by word-interleaved address bits.
- Contention per bank is resolved by an arbiter.
- Read responses (and optionally write responses) are routed back to the originator one cycle after grant.
- Sits between tile master ports and bank slave ports, one instance per banking-factor slice of the cluster.

Parameters:
NumIn, 4, number of master (initiator) ports; >=1.
NumOut, 4, number of bank ports; power of two, >=1.
AddrWidth, 32, master byte-address width.
DataWidth, 32, data width; multiple of 8.
AddrMemWidth, 10, bank word-address width.
WriteRespOn, 1, 1 = writes also produce vld_o; 0 = only reads produce vld_o.

Ports:
clk_i  in  1  clock, rising edge.
rst_i  in  1  synchronous active-high reset.
req_i  in  NumIn  master request.
add_i  in  NumIn x AddrWidth  byte address.
wen_i  in  NumIn  1 = write, 0 = read.
wdata_i  in  NumIn x DataWidth  write data.
be_i  in  NumIn x DataWidth/8  byte enables.
gnt_o  out  NumIn  request accepted this cycle.
vld_o  out  NumIn  response valid.
rdata_o  out  NumIn x DataWidth  response data.
req_o  out  NumOut  bank request.
gnt_i  in  NumOut  bank ready; may be tied to req_o.
add_o  out  NumOut x AddrMemWidth  bank word address.
wen_o  out  NumOut  bank write enable.
wdata_o  out  NumOut x DataWidth  bank write data.
be_o  out  NumOut x DataWidth/8  bank byte enables.
rdata_i  in  NumOut x DataWidth  bank read data, valid 1 cycle after accepted bank request.

Behaviour:
- Address decode:
  - OffW = log2(DataWidth/8); SelW = log2(NumOut) (0 if NumOut=1).
  - Target bank = add_i[OffW +: SelW].
  - Bank address add_o = add_i[OffW+SelW +: AddrMemWidth].
  - Bits outside these fields are ignored.
- Arbitration (per bank, combinational):
  - Candidates are inputs with req_i=1 targeting that bank.
  - Winner is chosen round-robin: first candidate at index >= pointer, wrapping.
  - req_o=1 iff any candidate exists.
  - add_o/wen_o/wdata_o/be_o come from the winner; they are 0 when there is no winner.
- gnt_o[i] = 1 iff input i is the winner of its target bank AND gnt_i of that bank is 1. Purely combinational, same cycle as req_i.
- A request is accepted when req_o & gnt_i.
  - On accept, that bank's pointer becomes (winner+1) mod NumIn.
  - Otherwise the pointer holds.
- Response path:
  - Per bank, register a valid bit and the winner index on each accept.
  - The valid bit is set for reads; it is set for writes only if WriteRespOn=1.
  - Next cycle: vld_o[idx]=1 and rdata_o[idx]=rdata_i[bank].
  - Each input targets one bank per cycle, so at most one response per input per cycle; no queueing.
- rdata_o is 0 when vld_o=0.
- Writes with WriteRespOn=1 return vld_o with rdata_o = bank rdata_i (don't-care content).
- Back-to-back: an input granted on consecutive cycles gets vld_o on consecutive cycles. Full throughput: each bank accepts one request per cycle.
- Ungranted masters must hold the request; no internal buffering.
- Reset (sync, rst_i=1 at clock edge):
  - All pointers go to 0.
  - Response valid registers are cleared, so vld_o=0 and rdata_o=0 the following cycle.
  - A request accepted in the same cycle as reset produces no response.
  - Combinational outputs keep following their inputs during reset.
- NumIn=1: the arbiter degenerates to a pass-through.
- NumOut=1: all requests map to bank 0.

Optional Feature:
TCDM_XBAR_RR_EN:
- Defined: round-robin arbitration as above.
- Undefined: fixed priority, lowest input index wins. No pointer registers exist; everything else is unchanged.

Test Plan:
1. NumIn=NumOut=4, gnt_i tied to req_o; input 0 reads add_i=0x0000_0024 → req_o[1]=1, add_o[1]=0x002, gnt_o[0]=1 same cycle. Next cycle rdata_i[1]=0xDEADBEEF → vld_o[0]=1, rdata_o[0]=0xDEADBEEF.
2. Inputs 0,1,2 all read bank 2 (addr 0x8) for 3 cycles, round-robin enabled → grants in order 0, 1, 2. Each vld_o follows its grant by one cycle; no two grants in one cycle.
3. Four inputs target four distinct banks → all gnt_o=1 in one cycle; all four vld_o=1 the next cycle with the correct per-bank data.
4. Write wen_i=1, be_i=0x3, wdata_i=0x1234_5678 to bank 3 → wen_o[3]=1, be_o[3]=0x3, wdata_o[3] matches. vld_o pulses next cycle only when WriteRespOn=1.
5. gnt_i[0]=0 while input 2 requests bank 0 → gnt_o[2]=0, no vld_o, pointer unchanged. Raising gnt_i grants input 2 the same cycle.
6. Assert rst_i in the cycle a read is granted → vld_o=0 next cycle; after release, round-robin restarts from input 0.
